pc_fetch_stage: RTL
===================

# pc_fetch_stage

Program-counter and fetch-sequencing stage directly upstream of the control unit. Owns the architectural PC, drives the instruction-memory address (`oPC`) into the control unit, and consumes the control unit's branch decision (`iPCSrc`) and immediate (`iImmExt`) to compute the next PC. Adds a valid/ready handshake toward decode, a one-cycle redirect bubble, misalignment fault detection and a retired-instruction counter.

## Interface
- `RESET_VECTOR`, default `32'h0000_0000`: PC loaded on reset; must be 4-byte aligned.
- `iClk`  in  1: clock; all state updates on the rising edge.
- `iRst`  in  1: asynchronous, active-high reset.
- `iReady`  in  1: decode/execute accepts the instruction at `oPC` this cycle.
- `iPCSrc`  in  1: taken branch or JAL for the current instruction (from control unit).
- `iJalr`  in  1: current instruction is JALR; target is register-relative.
- `iImmExt`  in  32: sign-extended immediate of the current instruction.
- `iRs1Data`  in  32: rs1 operand, used only when `iJalr`=1.
- `oPC`  out  32: registered fetch address to the control unit.
- `oPCPlus4`  out  32: `oPC`+4, combinational; link value for JAL/JALR.
- `oValid`  out  1: instruction at `oPC` is valid for decode.
- `oFault`  out  1: sticky misaligned-target fault.
- `oRetired`  out  32: count of accepted instructions.

## Operation
- States: RESET, RUN, REDIRECT, HALT (2-bit encoding).
- `oValid` = 1 only in RUN. Accept = `oValid & iReady`.
- Next-PC selection, evaluated only on accept:
  - `iJalr`=1: target = (`iRs1Data` + `iImmExt`) & `32'hFFFF_FFFE`.
  - else `iPCSrc`=1: target = `oPC` + `iImmExt`.
  - else: `oPC` + 4.
- All additions are 32-bit modulo 2^32; wrap-around is not an error (`32'hFFFF_FFFC` + 4 = `0`).
- Misaligned target (`target[1:0]` != 0 after the JALR mask) on a redirecting accept: PC holds, `oFault` is set, state goes to HALT, and `oRetired` still increments (the faulting instruction counts as retired).
- Transitions:
  - RESET -> RUN on the first edge after reset release; PC unchanged.
  - RUN, no accept -> RUN; PC holds and the `iPCSrc`/`iJalr` inputs are ignored.
  - RUN, accept, sequential -> RUN; PC <= PC+4.
  - RUN, accept, redirect, aligned -> REDIRECT; PC <= target.
  - RUN, accept, redirect, misaligned -> HALT.
  - REDIRECT -> RUN unconditionally. The cycle is a bubble so synchronous instruction memory can return the target word. `iReady` is ignored.
  - HALT -> HALT until reset.
- Priority: `iRst` > fault > redirect > stall (`iReady`=0) > increment.
- `oRetired` increments by 1 on each accept and wraps at 2^32.

## Timing
- Reset values: `oPC`=`RESET_VECTOR`, state=RESET, `oValid`=0, `oFault`=0, `oRetired`=0. `oPCPlus4` follows `oPC` combinationally.
- Reset asserted mid-operation clears everything immediately and asynchronously, including HALT and `oFault`.
- Latency: after reset release, `oValid` rises at the first edge.
- Sequential throughput: 1 instruction/cycle while `iReady`=1.
- Taken branch: new `oPC` visible 1 cycle after the accept edge, with `oValid`=0 in that cycle. The target instruction becomes valid on the following edge, so the penalty is 1 cycle.
- `iPCSrc`, `iJalr`, `iImmExt` and `iRs1Data` are sampled only on the accepting edge; they may be X otherwise.
- `oFault` rises at the edge of the faulting accept and stays high until reset.

## Test plan
- Reset and sequential fetch: `RESET_VECTOR`=0, `iReady`=1 for 5 cycles -> `oValid` goes 0 then 1; `oPC` steps 0,4,8,C,10; `oRetired`=4 after the fourth accept.
- Stall: at `oPC`=8 hold `iReady`=0 for 3 cycles while driving `iPCSrc`=1 -> `oPC` stays 8, `oRetired` unchanged, no redirect occurs; on releasing `iReady` with `iPCSrc`=0 -> `oPC`=C.
- Branch: at `oPC`=`32'h10` accept with `iPCSrc`=1 and `iImmExt`=`32'hFFFF_FFF8` -> next `oPC`=8 with `oValid`=0 for one cycle, then `oValid`=1; `oPCPlus4` at the branch cycle reads `32'h14`.
- JALR: `iRs1Data`=`32'h101`, `iImmExt`=`32'h3` -> target `32'h104`, enter REDIRECT, no fault.
- Misaligned fault: at `oPC`=`32'h20` accept with `iPCSrc`=1 and `iImmExt`=`32'h6` -> `oFault`=1, `oPC` stays `32'h20`, `oValid`=0 permanently, `oRetired` increments once; then assert `iRst` asynchronously mid-cycle -> all outputs return to reset values immediately.
- Wrap: `RESET_VECTOR`=`32'hFFFF_FFFC`, one sequential accept -> `oPC`=0, no fault.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// Program counter and fetch sequencer: owns the architectural PC, handshakes with decode,
// inserts a one-cycle bubble after every redirect and halts on a misaligned target.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReady,
    input  logic        iPCSrc,
    input  logic        iJalr,
    input  logic [31:0] iImmExt,
    input  logic [31:0] iRs1Data,
    output logic [31:0] oPC,
    output logic [31:0] oPCPlus4,
    output logic        oValid,
    output logic        oFault,
    output logic [31:0] oRetired
);

    typedef enum logic [1:0] {
        ST_RESET    = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fault_q, fault_d;
    logic [31:0] retired_q, retired_d;

    logic        accept;
    logic        redirect;
    logic [31:0] seq_pc;
    logic [31:0] branch_pc;
    logic [31:0] jalr_pc;
    logic [31:0] target_pc;
    logic        target_misaligned;

    assign accept    = (state_q == ST_RUN) && iReady;
    assign redirect  = iJalr || iPCSrc;
    assign seq_pc    = pc_q + 32'd4;
    assign branch_pc = pc_q + iImmExt;
    // JALR clears bit 0 of the sum before the alignment check, so only bit 1 can fault there.
    assign jalr_pc   = (iRs1Data + iImmExt) & 32'hFFFF_FFFE;
    assign target_pc = iJalr ? jalr_pc : branch_pc;
    assign target_misaligned = (target_pc[1:0] != 2'b00);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fault_d   = fault_q;
        retired_d = retired_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (accept) begin
                    // A faulting instruction still counts as retired.
                    retired_d = retired_q + 32'd1;
                    if (redirect) begin
                        if (target_misaligned) begin
                            fault_d = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            pc_d    = target_pc;
                            state_d = ST_REDIRECT;
                        end
                    end else begin
                        pc_d = seq_pc;
                    end
                end
            end
            // Bubble while synchronous instruction memory returns the target word.
            ST_REDIRECT: begin
                state_d = ST_RUN;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q   <= ST_RESET;
            pc_q      <= RESET_VECTOR;
            fault_q   <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    assign oPC      = pc_q;
    assign oPCPlus4 = seq_pc;
    assign oValid   = (state_q == ST_RUN);
    assign oFault   = fault_q;
    assign oRetired = retired_q;

endmodule
